grid_arbiter: RTL

Round-robin arbiter that shares the single-port 64x32x3 grid RAM among up to eight requesters: level loader, grid drawer, raytracer, player updater and enemy updater. It replaces the FSM-driven static grid mux in the main datapath, so sub-units can run concurrently. Each requester sees a one-cycle grant/read-valid handshake. An optional lock lets one requester do an uninterrupted read-modify-write sequence.

---
 rtl/grid_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/grid_arbiter.sv
// Round-robin arbiter sharing the single-port 64x32x3 grid RAM among NUM_REQ requesters.
// Optional feature: define GRID_ARB_LOCK_EN to honour req_lock (hold, timeout, sticky lock_err).
module grid_arbiter #(
   parameter int unsigned NUM_REQ  = 5,
   parameter int unsigned LOCK_MAX = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_we,
   input  logic [6*NUM_REQ-1:0] req_x,
   input  logic [5*NUM_REQ-1:0] req_y,
   input  logic [3*NUM_REQ-1:0] req_din,
   input  logic [NUM_REQ-1:0]   req_lock,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   rvalid,
   output logic [2:0]           rdata,
   output logic [5:0]           grid_x,
   output logic [4:0]           grid_y,
   output logic                 grid_write,
   output logic [2:0]           grid_in,
   input  logic [2:0]           grid_out,
   output logic                 lock_err
);

   function automatic logic [2:0] wrap_add(input logic [2:0] base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return 3'(s);
   endfunction

   logic [2:0] ptr;
   logic [2:0] ptr_next;
   logic [2:0] rr_idx;
   logic [2:0] gnt_sel;
   logic       rr_hit;
   logic       gnt_valid;

   // First pending requester in circular order starting at ptr.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!rr_hit && req[wrap_add(ptr, k)]) begin
            rr_hit = 1'b1;
            rr_idx = wrap_add(ptr, k);
         end
      end
   end

`ifdef GRID_ARB_LOCK_EN
   typedef enum logic {ARB, LOCKED} state_t;

   state_t     state;
   state_t     state_next;
   logic [2:0] owner;
   logic [2:0] owner_next;
   logic [7:0] lock_cnt;
   logic [7:0] lock_cnt_next;
   logic       lock_err_next;
   logic       lock_timeout;

   assign lock_timeout = (state == LOCKED) && (lock_cnt == 8'(LOCK_MAX));

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ARB;
         owner    <= '0;
         lock_cnt <= '0;
         lock_err <= 1'b0;
      end else begin
         state    <= state_next;
         owner    <= owner_next;
         lock_cnt <= lock_cnt_next;
         lock_err <= lock_err_next;
      end
   end

   always_comb begin
      state_next    = state;
      owner_next    = owner;
      lock_cnt_next = lock_cnt;
      lock_err_next = lock_err;
      ptr_next      = ptr;
      case (state)
         ARB: begin
            if (rr_hit) begin
               ptr_next = wrap_add(rr_idx, 1);
               if (req_lock[rr_idx]) begin
                  state_next    = LOCKED;
                  owner_next    = rr_idx;
                  lock_cnt_next = '0;
               end
            end
         end
         LOCKED: begin
            // ptr already points past the owner; it only moves again on a forced release.
            lock_cnt_next = lock_cnt + 8'd1;
            if (lock_timeout) begin
               state_next    = ARB;
               lock_err_next = 1'b1;
               ptr_next      = wrap_add(owner, 1);
            end else if (!req[owner] || !req_lock[owner]) begin
               state_next = ARB;
            end
         end
      endcase
   end

   always_comb begin
      gnt_valid = 1'b0;
      gnt_sel   = '0;
      if (!reset) begin
         if (state == LOCKED) begin
            gnt_valid = req[owner] && !lock_timeout;
            gnt_sel   = owner;
         end else begin
            gnt_valid = rr_hit;
            gnt_sel   = rr_idx;
         end
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^{req_lock, 32'(LOCK_MAX)};
   assign lock_err    = 1'b0;

   always_comb begin
      ptr_next  = rr_hit ? wrap_add(rr_idx, 1) : ptr;
      gnt_valid = rr_hit && !reset;
      gnt_sel   = rr_idx;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr    <= '0;
         rvalid <= '0;
      end else begin
         ptr    <= ptr_next;
         rvalid <= gnt & ~req_we;
      end
   end

   always_comb begin
      gnt        = '0;
      grid_x     = '0;
      grid_y     = '0;
      grid_write = 1'b0;
      grid_in    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_valid && gnt_sel == 3'(i)) begin
            gnt[i]     = 1'b1;
            grid_x     = req_x[6*i +: 6];
            grid_y     = req_y[5*i +: 5];
            grid_write = req_we[i];
            grid_in    = req_din[3*i +: 3];
         end
      end
   end

   assign rdata = grid_out;

endmodule
